cosim_array_packer: RTL and testbench
=====================================

COSIM_ARRAY_PACKER -- requirements
Module: cosim_array_packer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of unpacked element slots per frame.
REQ-002 SHALL have parameter ROWS, default 3, meaning outer packed dimension of one element.
REQ-003 SHALL have parameter COLS, default 2, meaning inner packed dimension of one element.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  element offered.
REQ-007 SHALL have port in_ready  output  1  element accepted when in_valid and in_ready are both high.
REQ-008 SHALL have port in_data  input  logic[ROWS-1:0][COLS-1:0]  one 2-packed-dimension element.
REQ-009 SHALL have port in_last  input  1  element closes the current frame early.
REQ-010 SHALL have port out_valid  output  1  frame available.
REQ-011 SHALL have port out_ready  input  1  frame consumed when out_valid and out_ready are both high.
REQ-012 SHALL have port out_frame  output  logic[ROWS-1:0][COLS-1:0] [DEPTH-1:0]  unpacked frame; slot 0 holds the first accepted element.
REQ-013 SHALL have port out_count  output  $clog2(DEPTH+1)  number of valid slots in out_frame, 1..DEPTH while out_valid.

Function
REQ-014 SHALL use two states: FILL (collecting) and FULL (frame held for output).
REQ-015 SHALL drive in_ready = 1 in FILL; in FULL, in_ready = out_ready.
REQ-016 SHALL, in FILL on acceptance, write in_data to slot[count] and increment count.
REQ-017 SHALL go FILL->FULL on the edge that accepts the DEPTH-th element or any element with in_last=1.
REQ-018 SHALL, on early close, zero all slots above the last written slot in the same edge; out_count = slots written.
REQ-019 SHALL drive out_valid = 1 exactly in FULL; out_frame and out_count stable while out_valid=1 and out_ready=0.
REQ-020 SHALL go FULL->FILL with count=0 on out_ready=1 when no element is accepted that cycle.
REQ-021 SHALL, in FULL with out_ready=1 and in_valid=1 (simultaneous drain and accept), write in_data to slot 0, set count=1, clear slots 1..DEPTH-1, and go to FILL; if that element has in_last=1 or DEPTH=1, stay in FULL with out_count=1.
REQ-022 SHALL have zero bubble: sustained in_valid=1 and out_ready=1 yields one frame every DEPTH accepted elements.
REQ-023 SHALL have latency of one cycle from the closing-element edge to out_valid=1.
REQ-024 SHALL ignore in_data and in_last whenever in_valid=0.
REQ-025 SHALL wrap count only by frame completion; count never exceeds DEPTH.

Reset
REQ-026 SHALL, while reset=1, asynchronously force state=FILL, count=0, all out_frame slots = 0, out_count = 0, out_valid = 0.
REQ-027 SHALL drive in_ready = 0 while reset=1, regardless of state.
REQ-028 SHALL discard any partially collected or undelivered frame when reset asserts mid-operation; the first edge after deassertion starts a fresh frame at slot 0.

Structure
REQ-029 SHALL place the element typedef (logic[ROWS-1:0][COLS-1:0] for defaults), default DEPTH/ROWS/COLS constants and the FILL/FULL state enum in shared package cosim_array_pkg.
REQ-030 SHALL be a single module with no sub-modules; its out_frame connects directly to the a input of the 2-packed/1-unpacked pass-through array test module.

Verification
REQ-031 SHALL pass this case: reset, then elements 6'h01,6'h02,6'h03,6'h04 on consecutive cycles, out_ready=1 -> one cycle later out_valid=1, slots[0..3]=01,02,03,04, out_count=4.
REQ-032 SHALL pass this case: elements 6'h2A,6'h15 with in_last on 6'h15 -> out_frame={0,0,15,2A} (slot3..0), out_count=2.
REQ-033 SHALL pass this case: frame full, out_ready=0 for 5 cycles, in_valid=1 -> in_ready=0 and out_frame unchanged for all 5 cycles; then out_ready=1 accepts next element into slot 0 the same cycle.
REQ-034 SHALL pass this case: 12 elements 6'h00..6'h0B streamed with in_valid=1 and out_ready=1 continuously -> three frames {00..03},{04..07},{08..0B} with no idle cycles on in_ready.
REQ-035 SHALL pass this case: reset asserted after 2 of 4 elements accepted -> out_valid=0 and in_ready=0 immediately, all slots 0; after release 4 new elements produce a frame with only the new values.
REQ-036 SHALL pass this case: round-trip through the 2-packed/1-unpacked pass-through module under cosimulation -> its b output equals out_frame bit-for-bit for every delivered frame.

Source files
------------

// File: rtl/cosim_array_pkg.sv
// Shared types and defaults for the frame packer and its cosim test harness.
package cosim_array_pkg;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_ROWS  = 3;
  localparam int DEF_COLS  = 2;

  typedef logic [DEF_ROWS-1:0][DEF_COLS-1:0] elem_t;

  typedef enum logic {ST_FILL = 1'b0, ST_FULL = 1'b1} state_e;
endpackage

// File: rtl/cosim_array_passthru.sv
// 2-packed/1-unpacked pass-through used to round-trip a packed frame across a cosim boundary.
module cosim_array_passthru #(
  parameter int DEPTH = 4,
  parameter int ROWS  = 3,
  parameter int COLS  = 2
) (
  input  logic [ROWS-1:0][COLS-1:0] a [DEPTH],
  output logic [ROWS-1:0][COLS-1:0] b [DEPTH]
);
  assign b = a;
endmodule

// File: rtl/cosim_array_packer.sv
// Collects 2-D packed elements into an unpacked frame of DEPTH slots, closing early on in_last.
module cosim_array_packer
  import cosim_array_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  localparam int CW   = $clog2(DEPTH+1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ROWS-1:0][COLS-1:0] in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ROWS-1:0][COLS-1:0] out_frame [DEPTH],
  output logic [CW-1:0]             out_count
);
  typedef logic [ROWS-1:0][COLS-1:0] slot_t;

  state_e         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  slot_t          slots_q [DEPTH];
  slot_t          slots_d [DEPTH];
  logic           accept;
  logic           closing;

  assign in_ready  = !reset && ((state_q == ST_FILL) || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_FULL);
  assign out_count = (state_q == ST_FULL) ? count_q : '0;
  assign out_frame = slots_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    slots_d = slots_q;
    closing = 1'b0;
    unique case (state_q)
      ST_FILL: begin
        if (accept) begin
          closing = in_last || (count_q + CW'(1) == CW'(DEPTH));
          count_d = count_q + CW'(1);
          for (int i = 0; i < DEPTH; i++) begin
            if (count_q == CW'(i))
              slots_d[i] = in_data;
            else if (closing && i > int'(count_q))
              slots_d[i] = '0;
          end
          if (closing) state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          if (in_valid) begin
            // Drain and restart in one edge: the new element opens the next frame.
            for (int i = 0; i < DEPTH; i++) slots_d[i] = '0;
            slots_d[0] = in_data;
            count_d    = CW'(1);
            state_d    = (in_last || DEPTH == 1) ? ST_FULL : ST_FILL;
          end else begin
            count_d = '0;
            state_d = ST_FILL;
          end
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FILL;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) slots_q[i] <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      slots_q <= slots_d;
    end
  end
endmodule

// File: tb/tb_cosim_array_packer.sv
// Directed bench for cosim_array_packer with a queue-based frame model and cosim round-trip check.
module tb_cosim_array_packer;
  import cosim_array_pkg::*;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH+1);

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, in_last, out_valid, out_ready;
  elem_t in_data;
  elem_t out_frame [DEPTH];
  elem_t pt_b [DEPTH];
  logic [CW-1:0] out_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cosim_array_packer #(.DEPTH(DEPTH), .ROWS(3), .COLS(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_frame(out_frame), .out_count(out_count)
  );

  cosim_array_passthru #(.DEPTH(DEPTH), .ROWS(3), .COLS(2)) u_pt (
    .a(out_frame), .b(pt_b)
  );

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endfunction

  // Model: elements gathered into a queue; a closed frame waits in held_f until drained.
  elem_t cur_q[$];
  elem_t held_f [DEPTH];
  int    held_n;
  bit    held_v;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_q.delete();
      held_v = 0;
      held_n = 0;
      for (int i = 0; i < DEPTH; i++) held_f[i] = '0;
    end else begin
      bit rdy;
      rdy = !held_v || out_ready;
      if (held_v && out_ready) held_v = 0;
      if (in_valid && rdy) begin
        cur_q.push_back(in_data);
        if (cur_q.size() == DEPTH || in_last) begin
          for (int i = 0; i < DEPTH; i++) held_f[i] = (i < cur_q.size()) ? cur_q[i] : '0;
          held_n = cur_q.size();
          held_v = 1;
          cur_q.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(!reset && (!held_v || out_ready)));
    chk("out_valid", 32'(out_valid), 32'(held_v));
    if (held_v) begin
      chk("out_count", 32'(out_count), 32'(held_n));
      for (int i = 0; i < DEPTH; i++) begin
        chk($sformatf("slot%0d", i), 32'(out_frame[i]), 32'(held_f[i]));
        chk($sformatf("cosim_b%0d", i), 32'(pt_b[i]), 32'(held_f[i]));
      end
    end
    if (reset) begin
      chk("rst_count", 32'(out_count), 32'd0);
      for (int i = 0; i < DEPTH; i++) chk($sformatf("rst_slot%0d", i), 32'(out_frame[i]), 32'd0);
    end
  end

  task automatic cyc(input logic v, input logic [5:0] d, input logic l, input logic ordy);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_frame(string nm, input logic [5:0] s0, s1, s2, s3, input int cnt);
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_cnt"}, 32'(out_count), 32'(cnt));
    chk({nm, "_s0"}, 32'(out_frame[0]), 32'(s0));
    chk({nm, "_s1"}, 32'(out_frame[1]), 32'(s1));
    chk({nm, "_s2"}, 32'(out_frame[2]), 32'(s2));
    chk({nm, "_s3"}, 32'(out_frame[3]), 32'(s3));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;

    // Full frame of four
    for (int i = 1; i <= 4; i++) cyc(1'b1, 6'(i), 1'b0, 1'b1);
    chk_frame("full4", 6'h01, 6'h02, 6'h03, 6'h04, 4);
    cyc(1'b0, 6'h00, 1'b0, 1'b1);

    // Early close after two; stale upper slots must read zero
    cyc(1'b1, 6'h2A, 1'b0, 1'b0);
    cyc(1'b1, 6'h15, 1'b1, 1'b0);
    chk_frame("early2", 6'h2A, 6'h15, 6'h00, 6'h00, 2);

    // Drain plus single-element last frame in the same edge
    cyc(1'b1, 6'h33, 1'b1, 1'b1);
    chk_frame("drain_last", 6'h33, 6'h00, 6'h00, 6'h00, 1);
    cyc(1'b0, 6'h3F, 1'b1, 1'b1);
    chk("idle_ignored", 32'(out_valid), 32'd0);

    // Backpressure for five cycles
    for (int i = 0; i < 4; i++) cyc(1'b1, 6'h10 + 6'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 6'h20 + 6'(i), 1'b0, 1'b0);
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk_frame("bp_hold", 6'h10, 6'h11, 6'h12, 6'h13, 4);
    end
    cyc(1'b1, 6'h3C, 1'b0, 1'b1);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_s0", 32'(out_frame[0]), 32'h3C);
    chk("bp_release_s1", 32'(out_frame[1]), 32'h00);
    for (int i = 1; i < 4; i++) cyc(1'b1, 6'h3C + 6'(i), 1'b0, 1'b1);
    chk_frame("bp_next", 6'h3C, 6'h3D, 6'h3E, 6'h3F, 4);

    // Zero-bubble streaming of twelve elements
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 6'(i), 1'b0, 1'b1);
      chk("stream_ready", 32'(in_ready), 32'd1);
      if (i % 4 == 3)
        chk_frame("stream", 6'(i-3), 6'(i-2), 6'(i-1), 6'(i), 4);
    end
    cyc(1'b0, 6'h00, 1'b0, 1'b1);

    // Reset mid-frame
    cyc(1'b1, 6'h11, 1'b0, 1'b0);
    cyc(1'b1, 6'h12, 1'b0, 1'b0);
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd0);
    chk("midrst_s0", 32'(out_frame[0]), 32'd0);
    chk("midrst_s1", 32'(out_frame[1]), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1'b1, 6'h21 + 6'(i), 1'b0, 1'b0);
    chk_frame("post_rst", 6'h21, 6'h22, 6'h23, 6'h24, 4);
    cyc(1'b0, 6'h00, 1'b0, 1'b1);
    cyc(1'b0, 6'h00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
